// File: rtl/rr_grant_stage_npu.sv
// Registered round-robin grant stage: pointer-masked priority encode with a held grant and valid/ready handshake.
// Optional grant_count output (32-bit acceptance counter) is enabled by defining RR_GRANT_COUNT_EN.
module rr_grant_stage_npu #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] grant_oh,
  input  logic               grant_ready,
  output logic [ID_W-1:0]    ptr
`ifdef RR_GRANT_COUNT_EN
  ,
  output logic [31:0]        grant_count
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  logic               accept;
  logic [ID_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0] arb_req;
  logic [ID_W-1:0]    arb_ptr;
  logic [ID_W-1:0]    arb_id;
  logic [NUM_REQ-1:0] arb_oh;

  // Lowest requester at or above p; falls back to lowest overall when none sit at/above p.
  function automatic logic [ID_W-1:0] sel(input logic [NUM_REQ-1:0] r,
                                          input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] hi_id;
    logic [ID_W-1:0] lo_id;
    logic            hi_hit;
    logic            lo_hit;
    hi_id  = '0;
    lo_id  = '0;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r[i] && !lo_hit) begin
        lo_id  = ID_W'(i);
        lo_hit = 1'b1;
      end
      if (r[i] && !hi_hit && (ID_W'(i) >= p)) begin
        hi_id  = ID_W'(i);
        hi_hit = 1'b1;
      end
    end
    return hi_hit ? hi_id : lo_id;
  endfunction

  function automatic logic [NUM_REQ-1:0] decode(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      oh[i] = (ID_W'(i) == id);
    end
    return oh;
  endfunction

  // In GRANT the arbiter only matters on acceptance: it sees req minus the accepted bit and the advanced pointer.
  always_comb begin
    accept   = grant_valid & grant_ready;
    ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    arb_req  = (state == GRANT) ? (req & ~grant_oh) : req;
    arb_ptr  = (state == GRANT) ? ptr_next : ptr;
    arb_id   = sel(arb_req, arb_ptr);
    arb_oh   = decode(arb_id);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      grant_oh    <= '0;
      ptr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_id    <= arb_id;
            grant_oh    <= arb_oh;
          end
        end
        GRANT: begin
          if (accept) begin
            ptr <= ptr_next;
            if (|arb_req) begin
              grant_id <= arb_id;
              grant_oh <= arb_oh;
            end else begin
              state       <= IDLE;
              grant_valid <= 1'b0;
              grant_oh    <= '0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
          grant_oh    <= '0;
        end
      endcase
    end
  end

`ifdef RR_GRANT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_count <= '0;
    end else if (accept) begin
      grant_count <= grant_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_grant_stage_npu.sv
// Scoreboard bench for rr_grant_stage_npu (NUM_REQ=4); define RR_GRANT_COUNT_EN to also cover grant_count.
module tb_rr_grant_stage_npu;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] grant_oh;
  logic       grant_ready;
  logic [1:0] ptr;
`ifdef RR_GRANT_COUNT_EN
  logic [31:0] grant_count;
`endif

  rr_grant_stage_npu #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_oh    (grant_oh),
    .grant_ready (grant_ready),
    .ptr         (ptr)
`ifdef RR_GRANT_COUNT_EN
    ,
    .grant_count (grant_count)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [1:0] id;
    logic [3:0] oh;
    logic [1:0] p;
  } obs_t;

  // One cycle of stimulus plus the outputs expected after the following rising edge.
  typedef struct packed {
    logic       rn;
    logic [3:0] rq;
    logic       rdy;
    obs_t       ex;
    logic       care_id;
  } step_t;

  obs_t  obs;
  step_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  assign obs = {grant_valid, grant_id, grant_oh, ptr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  function automatic step_t mk(input logic rn, input logic [3:0] rq, input logic rdy,
                               input logic v, input logic [1:0] id, input logic [3:0] oh,
                               input logic [1:0] p, input logic care_id);
    step_t s;
    s.rn = rn; s.rq = rq; s.rdy = rdy;
    s.ex = '{v: v, id: id, oh: oh, p: p};
    s.care_id = care_id;
    return s;
  endfunction

  task automatic test_reset;
    step_t tbl[$];
    step_t e;
    obs_t  got;
    tbl.push_back(mk(0, 4'b1111, 0, 0, 2'd0, 4'b0000, 2'd0, 1));
    tbl.push_back(mk(0, 4'b1111, 0, 0, 2'd0, 4'b0000, 2'd0, 1));
    tbl.push_back(mk(1, 4'b1111, 0, 1, 2'd0, 4'b0001, 2'd0, 1));
    foreach (tbl[k]) begin
      reset_n = tbl[k].rn; req = tbl[k].rq; grant_ready = tbl[k].rdy;
      sb.push_back(tbl[k]);
      @(negedge clk);
      e = sb.pop_front();
      got = obs;
      if (!e.care_id) got.id = e.ex.id;
      n_cmp++;
      if (got !== e.ex)begin
        n_err++;
        $display("FAIL reset[%0d]: got v=%0b id=%0d oh=%b ptr=%0d, want v=%0b id=%0d oh=%b ptr=%0d",
                 k, got.v, got.id, got.oh, got.p, e.ex.v, e.ex.id, e.ex.oh, e.ex.p);
      end
    end
  endtask

  task automatic test_back_to_back;
    step_t tbl[$];
    step_t e;
    obs_t  got;
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] n;
      n = 2'(k % 4);
      tbl.push_back(mk(1, 4'b1111, 1, 1, n, 4'b0001 << n, n, 1));
    end
    foreach (tbl[k]) begin
      reset_n = tbl[k].rn; req = tbl[k].rq; grant_ready = tbl[k].rdy;
      sb.push_back(tbl[k]);
      @(negedge clk);
      e = sb.pop_front();
      got = obs;
      if (!e.care_id) got.id = e.ex.id;
      n_cmp++;
      if (got !== e.ex) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got v=%0b id=%0d oh=%b ptr=%0d, want v=%0b id=%0d oh=%b ptr=%0d",
                 k, got.v, got.id, got.oh, got.p, e.ex.v, e.ex.id, e.ex.oh, e.ex.p);
      end
    end
  endtask

  task automatic test_backpressure;
    step_t tbl[$];
    step_t e;
    obs_t  got;
    tbl.push_back(mk(0, 4'b0101, 0, 0, 2'd0, 4'b0000, 2'd0, 1));
    tbl.push_back(mk(1, 4'b0101, 0, 1, 2'd0, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(1, 4'b1000, 0, 1, 2'd0, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(1, 4'b1000, 0, 1, 2'd0, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(1, 4'b1000, 0, 1, 2'd0, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(1, 4'b1000, 1, 1, 2'd3, 4'b1000, 2'd1, 1));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 4'b0000, 2'd0, 0));
    foreach (tbl[k]) begin
      reset_n = tbl[k].rn; req = tbl[k].rq; grant_ready = tbl[k].rdy;
      sb.push_back(tbl[k]);
      @(negedge clk);
      e = sb.pop_front();
      got = obs;
      if (!e.care_id) got.id = e.ex.id;
      n_cmp++;
      if (got !== e.ex) begin
        n_err++;
        $display("FAIL backpressure[%0d]: got v=%0b id=%0d oh=%b ptr=%0d, want v=%0b id=%0d oh=%b ptr=%0d",
                 k, got.v, got.id, got.oh, got.p, e.ex.v, e.ex.id, e.ex.oh, e.ex.p);
      end
    end
  endtask

  task automatic test_wrap_skip;
    step_t tbl[$];
    step_t e;
    obs_t  got;
    tbl.push_back(mk(0, 4'b0100, 0, 0, 2'd0, 4'b0000, 2'd0, 1));
    tbl.push_back(mk(1, 4'b0100, 0, 1, 2'd2, 4'b0100, 2'd0, 1));
    tbl.push_back(mk(1, 4'b1001, 1, 1, 2'd3, 4'b1000, 2'd3, 1));
    tbl.push_back(mk(1, 4'b1001, 1, 1, 2'd0, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 2'd1, 0));
    // Fallback path: nothing at/above the new pointer, lowest requester wins.
    tbl.push_back(mk(0, 4'b0010, 0, 0, 2'd0, 4'b0000, 2'd0, 1));
    tbl.push_back(mk(1, 4'b0010, 0, 1, 2'd1, 4'b0010, 2'd0, 1));
    tbl.push_back(mk(1, 4'b0011, 1, 1, 2'd0, 4'b0001, 2'd2, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 2'd0, 4'b0001, 2'd2, 1));
    foreach (tbl[k]) begin
      reset_n = tbl[k].rn; req = tbl[k].rq; grant_ready = tbl[k].rdy;
      sb.push_back(tbl[k]);
      @(negedge clk);
      e = sb.pop_front();
      got = obs;
      if (!e.care_id) got.id = e.ex.id;
      n_cmp++;
      if (got !== e.ex) begin
        n_err++;
        $display("FAIL wrap_skip[%0d]: got v=%0b id=%0d oh=%b ptr=%0d, want v=%0b id=%0d oh=%b ptr=%0d",
                 k, got.v, got.id, got.oh, got.p, e.ex.v, e.ex.id, e.ex.oh, e.ex.p);
      end
    end
  endtask

  task automatic test_reset_mid_grant;
    step_t tbl[$];
    step_t e;
    obs_t  got;
    tbl.push_back(mk(0, 4'b0100, 0, 0, 2'd0, 4'b0000, 2'd0, 1));
    tbl.push_back(mk(1, 4'b0100, 0, 1, 2'd2, 4'b0100, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0100, 1, 0, 2'd0, 4'b0000, 2'd0, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 4'b0000, 2'd0, 0));
    foreach (tbl[k]) begin
      reset_n = tbl[k].rn; req = tbl[k].rq; grant_ready = tbl[k].rdy;
      sb.push_back(tbl[k]);
      @(negedge clk);
      e = sb.pop_front();
      got = obs;
      if (!e.care_id) got.id = e.ex.id;
      n_cmp++;
      if (got !== e.ex) begin
        n_err++;
        $display("FAIL reset_mid_grant[%0d]: got v=%0b id=%0d oh=%b ptr=%0d, want v=%0b id=%0d oh=%b ptr=%0d",
                 k, got.v, got.id, got.oh, got.p, e.ex.v, e.ex.id, e.ex.oh, e.ex.p);
      end
`ifdef RR_GRANT_COUNT_EN
      if (k >= 2) begin
        n_cmp++;
        if (grant_count !== 32'd0) begin
          n_err++;
          $display("FAIL reset_mid_grant_count[%0d]: got %0d, want 0", k, grant_count);
        end
      end
`endif
    end
  endtask

`ifdef RR_GRANT_COUNT_EN
  task automatic test_count;
    logic       rn_t[$];
    logic       rdy_t[$];
    int         cnt_sb[$];
    int         want;
    rn_t.push_back(1'b0); rdy_t.push_back(1'b0); cnt_sb.push_back(0);
    rn_t.push_back(1'b1); rdy_t.push_back(1'b0); cnt_sb.push_back(0);
    for (int k = 1; k <= 10; k++) begin
      rn_t.push_back(1'b1); rdy_t.push_back(1'b1); cnt_sb.push_back(k);
    end
    for (int k = 0; k < 5; k++) begin
      rn_t.push_back(1'b1); rdy_t.push_back(1'b0); cnt_sb.push_back(10);
    end
    foreach (rn_t[k]) begin
      reset_n = rn_t[k]; req = 4'b1111; grant_ready = rdy_t[k];
      @(negedge clk);
      want = cnt_sb.pop_front();
      n_cmp++;
      if (grant_count !== 32'(want)) begin
        n_err++;
        $display("FAIL count[%0d]: got %0d, want %0d", k, grant_count, want);
      end
    end
  endtask
`endif

  initial begin
    reset_n     = 1'b0;
    req         = 4'b0000;
    grant_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid_grant();
`ifdef RR_GRANT_COUNT_EN
    test_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_grant_stage_npu.md
Name: rr_grant_stage_npu

Overview:
Registered round-robin arbitration stage that turns a vector of level requests into one held grant with a valid/ready handshake. It is a pointer-masked priority encode with the result registered. It sits directly downstream of request sources such as thread, warp or port request lines, and feeds issue/dispatch logic. It replaces ad-hoc fixed-priority LSB selection where fairness between requesters is needed.

Parameters:
NUM_REQ, 4, number of requesters; must be >= 2; need not be a power of 2
ID_W, $clog2(NUM_REQ), width of grant_id; derived, not overridden

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous reset, active-low
req  input  NUM_REQ  level requests; bit i = requester i wants service
grant_valid  output  1  registered; a grant is being offered
grant_id  output  ID_W  registered; index of granted requester
grant_oh  output  NUM_REQ  registered; one-hot copy of grant_id; all-zero when grant_valid=0
grant_ready  input  1  consumer accepts the grant this cycle when grant_valid=1
ptr  output  ID_W  current round-robin pointer, for debug and verification

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset, while reset_n=0 at clk edge:
  - grant_valid=0, grant_id=0, grant_oh=0, ptr=0, FSM=IDLE.
  - Reset mid-grant drops the grant with no acceptance recorded.
- Selection function sel(r, p):
  - m = r with bits below p cleared.
  - If m != 0, result = lowest set index of m; else result = lowest set index of r.
  - Purely combinational.
- FSM has 2 states.
- IDLE: grant_valid=0.
  - If |req, register grant_id=sel(req,ptr), set grant_oh accordingly, go to GRANT.
  - Latency: req asserted in cycle t, grant_valid=1 in cycle t+1.
- GRANT: grant_valid=1.
  - grant_id and grant_oh are held stable until acceptance. Changes on req, including withdrawal of the granted bit, are ignored.
  - Acceptance happens when grant_valid & grant_ready:
    - ptr <= (grant_id == NUM_REQ-1) ? 0 : grant_id+1.
    - Re-arbitrate in the same cycle on req' = req with bit grant_id cleared, using the new ptr value.
    - If req' != 0: stay in GRANT with the new grant registered. This gives back-to-back grants, 1 per cycle at full throughput.
    - If req' == 0: go to IDLE, grant_valid=0, grant_oh=0.
  - No acceptance: hold all outputs and ptr.
- Requester contract: drop its req bit the cycle after its grant is accepted. Bit masking covers the acceptance cycle only.
- ptr changes only on acceptance, never on offer.
- With all req bits set, grants rotate strictly 0,1,...,NUM_REQ-1,0.
- Width rules:
  - ptr and grant_id compare within ID_W bits.
  - For non-power-of-2 NUM_REQ, index values >= NUM_REQ never occur. The wrap is explicit, not modular overflow.
- grant_oh always equals the decode of grant_id when grant_valid=1.

Optional Feature:
Macro RR_GRANT_COUNT_EN.
- Defined:
  - Adds output port grant_count, 32 bits, reset 0.
  - Increments by 1 on every acceptance.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset by reset_n with all other state.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with req=1111 -> grant_valid=0, grant_oh=0000, ptr=0 throughout. Release -> grant_valid=1, grant_id=0 one cycle later.
2. Back-to-back rotation: NUM_REQ=4, req=1111 held, grant_ready=1 -> grant_id sequence 0,1,2,3,0 on consecutive cycles, with ptr 1,2,3,0,1 after each acceptance.
3. Backpressure: req=0101, grant_ready=0 for 3 cycles, req changed to 1000 during the stall -> grant_id=0 and grant_oh=0001 held stable, ptr=0. Then grant_ready=1 -> accept, next grant_id=3.
4. Pointer wrap and skip: ptr=3 (reached via accepted grant 2), req=1001 -> grant_id=3. Accept -> ptr=0, grant_id=0. Accept with req then 0000 -> IDLE, grant_valid=0.
5. Reset mid-grant: grant_valid=1, grant_id=2, reset_n=0 for 1 cycle -> next cycle grant_valid=0, ptr=0. With RR_GRANT_COUNT_EN, grant_count=0.
6. Counter (RR_GRANT_COUNT_EN): 10 accepted grants with req=1111, grant_ready=1, then 5 stall cycles -> grant_count=10, unchanged during the stall.
